// File: rtl/shop_pkg.sv
// Shared ASCII constants, receiver state type and command widths for the shop_v front end.
package shop_pkg;

  parameter int unsigned I_A_NUM_ASCII_CHARS = 7;
  parameter int unsigned I_U_NUM_BITS        = 4;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiSp = 8'h20;
  localparam logic [7:0] AsciiBs = 8'h08;

  typedef enum logic [1:0] {
    StTok,
    StNum,
    StDisc
  } rx_state_t;

endpackage

// File: rtl/shop_char_class.sv
// Combinational ASCII byte classifier used by the command receiver.
module shop_char_class
  import shop_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_term_o,
  output logic       is_sp_o,
  output logic       is_dig_o,
  output logic       is_prn_o,
  output logic       is_bs_o,
  output logic [3:0] digit_o
);

  logic [7:0] digit_full;

  always_comb begin
    is_term_o  = (byte_i == AsciiCr) || (byte_i == AsciiLf);
    is_sp_o    = (byte_i == AsciiSp);
    is_dig_o   = (byte_i >= 8'h30) && (byte_i <= 8'h39);
    is_prn_o   = (byte_i >= 8'h21) && (byte_i <= 8'h7E);
    is_bs_o    = (byte_i == AsciiBs);
    digit_full = byte_i - 8'h30;
    digit_o    = digit_full[3:0];
  end

  // Upper bits of the subtraction only matter for non-digits, where digit_o is not used.
  logic [3:0] unused_digit_hi;
  assign unused_digit_hi = digit_full[7:4];

endmodule

// File: rtl/shop_cmd_rx.sv
// Assembles an ASCII line "<token>[ <decimal>]<CR|LF>" into a one-cycle command for shop_v.
// Optional backspace editing is enabled by defining SHOP_CMD_RX_BACKSPACE_EN.
module shop_cmd_rx #(
  parameter int unsigned I_A_NUM_ASCII_CHARS = shop_pkg::I_A_NUM_ASCII_CHARS,
  parameter int unsigned I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
  parameter int unsigned I_U_NUM_BITS        = shop_pkg::I_U_NUM_BITS
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_rdy,
  output logic [I_A_NUM_BITS-1:0] o_a,
  output logic [I_U_NUM_BITS-1:0] o_u,
  output logic                    o_err
);

  import shop_pkg::*;

  localparam int unsigned N      = I_A_NUM_ASCII_CHARS;
  localparam int unsigned CntW   = $clog2(N + 1);
  localparam int unsigned NumW   = I_U_NUM_BITS + 4;
  localparam int unsigned NdigW  = 4;
  localparam logic [NumW-1:0] NumMax = NumW'((2 ** I_U_NUM_BITS) - 1);

  logic       is_term, is_sp, is_dig, is_prn, is_bs;
  logic [3:0] digit;

  shop_char_class u_class (
    .byte_i    (i_byte),
    .is_term_o (is_term),
    .is_sp_o   (is_sp),
    .is_dig_o  (is_dig),
    .is_prn_o  (is_prn),
    .is_bs_o   (is_bs),
    .digit_o   (digit)
  );

  rx_state_t               state_q;
  logic [N*8-1:0]          acc_q;
  logic [CntW-1:0]         cnt_q;
  logic [I_U_NUM_BITS-1:0] num_q;
  logic [NdigW-1:0]        ndig_q;
  logic                    rdy_q, err_q;
  logic [I_A_NUM_BITS-1:0] a_q;
  logic [I_U_NUM_BITS-1:0] u_q;

  logic            emit, drop;
  logic [NumW-1:0] num_ext;

  always_comb begin
    emit    = 1'b0;
    drop    = 1'b0;
    num_ext = NumW'(num_q) * NumW'(10) + NumW'(digit);
    if (i_valid && is_term) begin
      emit = ((state_q == StTok) && (cnt_q != '0)) || (state_q == StNum);
      drop = (state_q == StDisc);
    end
  end

`ifndef SHOP_CMD_RX_BACKSPACE_EN
  logic unused_bs;
  assign unused_bs = is_bs;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StTok;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      ndig_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      u_q     <= '0;
    end else begin
      rdy_q <= emit;
      err_q <= drop;
      if (emit || drop) begin
        // Clear on the terminator edge so the next byte starts a fresh line.
        if (emit) begin
          a_q <= I_A_NUM_BITS'(acc_q);
          u_q <= (state_q == StNum && ndig_q != '0) ? num_q : '0;
        end
        state_q <= StTok;
        acc_q   <= '0;
        cnt_q   <= '0;
        num_q   <= '0;
        ndig_q  <= '0;
      end else if (i_valid) begin
        unique case (state_q)
          StTok: begin
            if (is_sp) begin
              if (cnt_q != '0) begin
                state_q <= StNum;
                num_q   <= '0;
                ndig_q  <= '0;
              end
            end else if (is_prn) begin
              if (cnt_q == CntW'(N)) begin
                state_q <= StDisc;
              end else begin
                acc_q <= {acc_q[N*8-9:0], i_byte};
                cnt_q <= cnt_q + CntW'(1);
              end
            end
`ifdef SHOP_CMD_RX_BACKSPACE_EN
            else if (is_bs && cnt_q != '0) begin
              acc_q <= {8'h00, acc_q[N*8-1:8]};
              cnt_q <= cnt_q - CntW'(1);
            end
`endif
          end
          StNum: begin
            if (is_dig) begin
              if (num_ext > NumMax) begin
                state_q <= StDisc;
              end else begin
                num_q <= num_ext[I_U_NUM_BITS-1:0];
                if (ndig_q != '1) ndig_q <= ndig_q + NdigW'(1);
              end
            end else if (is_sp || is_prn) begin
              state_q <= StDisc;
            end
`ifdef SHOP_CMD_RX_BACKSPACE_EN
            else if (is_bs) begin
              if (ndig_q != '0) begin
                num_q  <= num_q / I_U_NUM_BITS'(10);
                ndig_q <= ndig_q - NdigW'(1);
              end else begin
                state_q <= StTok;
              end
            end
`endif
          end
          StDisc: ;
          default: state_q <= StTok;
        endcase
      end
    end
  end

  assign o_rdy = rdy_q;
  assign o_err = err_q;
  assign o_a   = a_q;
  assign o_u   = u_q;

endmodule

// File: tb/tb_shop_cmd_rx.sv
// Directed self-checking bench for shop_cmd_rx; expectation of the backspace case follows
// SHOP_CMD_RX_BACKSPACE_EN.
module tb_shop_cmd_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rdy, err;
  logic [55:0] a;
  logic [3:0]  u;

  int tests = 0;
  int failed = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int base;
  logic [55:0] exp_a;

  shop_cmd_rx dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (valid),
    .i_byte  (data),
    .o_rdy   (rdy),
    .o_a     (a),
    .o_u     (u),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy) rdy_cnt++;
    if (err) err_cnt++;
    if (rdy && err) both_cnt++;
  end

  `define CHK(tag, obs, exp) \
    tests++; \
    assert ((obs) === (exp)) else begin \
      failed++; \
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp); \
    end

  // Byte is driven at a negedge and accepted at the following posedge; returns one negedge later.
  task automatic send(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    @(negedge clk);
    valid = 1'b0;
    data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    `CHK("reset_rdy", rdy, 1'b0)
    `CHK("reset_err", err, 1'b0)
    `CHK("reset_a", a, 56'h0)
    `CHK("reset_u", u, 4'h0)

    // Single pulse one cycle after CR; trailing LF is an empty line.
    base = rdy_cnt;
    send_str("Login");
    `CHK("login_no_early_rdy", rdy, 1'b0)
    send(8'h0D);
    exp_a = "Login";
    `CHK("login_rdy", rdy, 1'b1)
    `CHK("login_a", a, exp_a)
    `CHK("login_u", u, 4'd0)
    send(8'h0A);
    `CHK("login_lf_no_rdy", rdy, 1'b0)
    repeat (2) @(negedge clk);
    `CHK("login_one_pulse", rdy_cnt - base, 1)

    send_str("Buy 12");
    send(8'h0A);
    exp_a = "Buy";
    `CHK("buy12_rdy", rdy, 1'b1)
    `CHK("buy12_a", a, exp_a)
    `CHK("buy12_u", u, 4'd12)
    send_str("Buy 16");
    send(8'h0A);
    `CHK("buy16_err", err, 1'b1)
    `CHK("buy16_no_rdy", rdy, 1'b0)
    `CHK("buy16_a_held", a, exp_a)
    `CHK("buy16_u_held", u, 4'd12)

    // Token overflow, then a max-length token back to back.
    send_str("AddItemX");
    send(8'h0A);
    `CHK("overflow_err", err, 1'b1)
    send_str("AddItem");
    send(8'h0A);
    exp_a = "AddItem";
    `CHK("additem_rdy", rdy, 1'b1)
    `CHK("additem_a", a, exp_a)

    send_str("Go 15");
    send(8'h0D);
    exp_a = "Go";
    `CHK("max_num_a", a, exp_a)
    `CHK("max_num_u", u, 4'd15)
    send_str("Ab ");
    send(8'h0A);
    exp_a = "Ab";
    `CHK("no_digits_a", a, exp_a)
    `CHK("no_digits_u", u, 4'd0)
    send_str("Ab 1x");
    send(8'h0A);
    `CHK("bad_digit_err", err, 1'b1)
    send_str(" Hi");
    send(8'h0A);
    exp_a = "Hi";
    `CHK("lead_space_a", a, exp_a)

    // Reset mid-line drops the partial token and clears outputs.
    base = rdy_cnt;
    send_str("Adm");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    `CHK("midreset_a", a, 56'h0)
    send_str("123");
    send(8'h0A);
    exp_a = "123";
    `CHK("after_reset_rdy", rdy, 1'b1)
    `CHK("after_reset_a", a, exp_a)
    `CHK("after_reset_pulses", rdy_cnt - base, 1)

    send_str("Usx");
    send(8'h08);
    send_str("1");
    send(8'h0A);
`ifdef SHOP_CMD_RX_BACKSPACE_EN
    exp_a = "Us1";
`else
    exp_a = "Usx1";
`endif
    `CHK("backspace_a", a, exp_a)

    repeat (3) @(negedge clk);
    `CHK("total_rdy", rdy_cnt, 8)
    `CHK("total_err", err_cnt, 3)
    `CHK("never_both", both_cnt, 0)

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
